// File: rtl/vga_timing_if.sv
// Signal bundle between the VGA raster timing generator and its display-path consumers.
// The generator takes the master modport; pixel logic or a driver takes the slave modport.
interface vga_timing_if #(
    parameter int XW  = 10,
    parameter int YW  = 10,
    parameter int FCW = 8
);
    logic           en;
    logic           resync;
    logic           hsync;
    logic           vsync;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           active;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_count;

    modport master (
        input  en, resync,
        output hsync, vsync, x, y, active, line_start, frame_start, frame_count
    );

    modport slave (
        output en, resync,
        input  hsync, vsync, x, y, active, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: x/y counters, syncs, data enable and strobes,
// all registered and derived from the next counter values so they line up with x/y.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int FCW       = 8
) (
    input  logic         vgaclk,
    input  logic         reset,
    vga_timing_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT_END  = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT_END  = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > (1 << XW)) begin : g_bad_xw
        $error("vga_timing_gen: H_TOTAL does not fit in XW bits");
    end
    if (V_TOTAL > (1 << YW)) begin : g_bad_yw
        $error("vga_timing_gen: V_TOTAL does not fit in YW bits");
    end

    logic [XW-1:0]  r_x, w_x_next;
    logic [YW-1:0]  r_y, w_y_next;
    logic [FCW-1:0] r_fc, w_fc_next;
    logic           r_hsync, r_vsync, r_active, r_line_start, r_frame_start;
    logic           w_line_start_next, w_frame_start_next;
    logic           w_in_hsync, w_in_vsync, w_active_next;

    // resync wins over en and over a coincident frame wrap, so frame_count is left alone
    always_comb begin
        w_x_next           = r_x;
        w_y_next           = r_y;
        w_fc_next          = r_fc;
        w_line_start_next  = 1'b0;
        w_frame_start_next = 1'b0;
        if (bus.resync) begin
            w_x_next           = '0;
            w_y_next           = '0;
            w_line_start_next  = 1'b1;
            w_frame_start_next = 1'b1;
        end else if (bus.en) begin
            if (r_x == X_LAST) begin
                w_x_next          = '0;
                w_line_start_next = 1'b1;
                if (r_y == Y_LAST) begin
                    w_y_next           = '0;
                    w_frame_start_next = 1'b1;
                    w_fc_next          = r_fc + FCW'(1);
                end else begin
                    w_y_next = r_y + YW'(1);
                end
            end else begin
                w_x_next = r_x + XW'(1);
            end
        end
    end

    // Decoding the next position keeps syncs cycle-aligned with the registered x/y
    always_comb begin
        w_in_hsync    = (w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST);
        w_in_vsync    = (w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST);
        w_active_next = (w_x_next < X_ACT_END) && (w_y_next < Y_ACT_END);
    end

    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_fc          <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_active      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_fc          <= w_fc_next;
            r_hsync       <= w_in_hsync ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_in_vsync ? VSYNC_POL : ~VSYNC_POL;
            r_active      <= w_active_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.frame_count = r_fc;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.active      = r_active;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen with a small raster; the reference tracks a linear
// pixel position within the frame and derives every output from it arithmetically.
module tb_vga_timing_gen;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int XW = 4, YW = 3, FCW = 2;

    logic vgaclk = 1'b0;
    logic reset  = 1'b1;
    always #5 vgaclk = ~vgaclk;

    vga_timing_if #(.XW(XW), .YW(YW), .FCW(FCW)) bus ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .XW(XW), .YW(YW), .FCW(FCW)
    ) dut (
        .vgaclk (vgaclk),
        .reset  (reset),
        .bus    (bus)
    );

    int m_p, m_fc;
    bit m_ls, m_fs;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p  = 0;
        m_fc = 0;
        m_ls = 0;
        m_fs = 0;
    endtask

    task automatic check_all();
        int ex, ey;
        ex = m_p % HT;
        ey = m_p / HT;
        chk("x", 32'(bus.x), ex);
        chk("y", 32'(bus.y), ey);
        chk("hsync", 32'(bus.hsync), (ex >= HA + HF && ex <= HA + HF + HS - 1) ? 1 : 0);
        chk("vsync", 32'(bus.vsync), (ey >= VA + VF && ey <= VA + VF + VS - 1) ? 1 : 0);
        chk("active", 32'(bus.active), (ex < HA && ey < VA) ? 1 : 0);
        chk("line_start", 32'(bus.line_start), m_ls);
        chk("frame_start", 32'(bus.frame_start), m_fs);
        chk("frame_count", 32'(bus.frame_count), m_fc);
    endtask

    // One vgaclk edge with the given inputs; the model advances alongside the DUT.
    task automatic step(input bit e, input bit rs);
        bus.en     = e;
        bus.resync = rs;
        @(posedge vgaclk);
        if (rs) begin
            m_p  = 0;
            m_ls = 1;
            m_fs = 1;
        end else if (e) begin
            m_p  = (m_p + 1) % FT;
            if (m_p == 0) m_fc = (m_fc + 1) % (1 << FCW);
            m_ls = (m_p % HT) == 0;
            m_fs = (m_p == 0);
        end else begin
            m_ls = 0;
            m_fs = 0;
        end
        #1;
        check_all();
    endtask

    initial begin
        int fc_before;
        bus.en     = 1'b0;
        bus.resync = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        #1 check_all();

        repeat (2) @(posedge vgaclk);
        #2 reset = 1'b1;
        #1 check_all();

        // Five full frames with en high: covers frame_count 3 -> 0
        for (int i = 0; i < 5 * FT; i++) step(1'b1, 1'b0);

        for (int i = 0; i < 2 * FT + 10; i++) step(i[0], 1'b0);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);

        for (int i = 0; i < 2 * FT && m_p != FT - 1; i++) step(1'b1, 1'b0);
        chk("reach_wrap", m_p, FT - 1);
        fc_before = m_fc;
        step(1'b1, 1'b1);
        chk("wrap_resync_fs", 32'(bus.frame_start), 1);
        chk("wrap_resync_fc", 32'(bus.frame_count), fc_before);

        for (int i = 0; i < 2 * FT && (m_p % HT) != 3; i++) step(1'b1, 1'b0);
        chk("reach_mid_line", m_p % HT, 3);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        bus.en = 1'b1;
        repeat (2) @(posedge vgaclk);
        #1 check_all();
        #2 reset = 1'b1;
        step(1'b1, 1'b0);
        chk("post_reset_x", 32'(bus.x), 1);
        chk("post_reset_ls", 32'(bus.line_start), 0);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It succeeds the fixed 640x480 `vgaController` and drives the same hsync/vsync/x/y consumers in the display path. It adds:
- configurable porch, sync and active timing
- sync polarity parameters
- a pixel-clock enable for divided clocks
- a data-enable output, line and frame strobes, a frame counter, and a synchronous resync input

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync width, lines
- V_BP, 33: vertical back porch, lines
- HSYNC_POL, 0: asserted level of hsync
- VSYNC_POL, 0: asserted level of vsync
- XW, 10: width of x; elaboration error if H_TOTAL > 2^XW
- YW, 10: width of y; elaboration error if V_TOTAL > 2^YW
- FCW, 8: width of frame_count

Ports:
- vgaclk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- en  in  1  pixel enable; counters advance only on vgaclk edges where en=1
- resync  in  1  synchronous restart to (0,0)
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- x  out  XW  horizontal counter, 0..H_TOTAL-1
- y  out  YW  vertical counter, 0..V_TOTAL-1
- active  out  1  x < H_ACTIVE and y < V_ACTIVE
- line_start  out  1  one-cycle pulse on entering x=0
- frame_start  out  1  one-cycle pulse on entering (0,0)
- frame_count  out  FCW  completed-frame counter, wraps modulo 2^FCW

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Normal counting (en=1, resync=0):
  - x increments each edge.
  - When x = H_TOTAL-1, x goes to 0 and y increments.
  - When also y = V_TOTAL-1, y goes to 0 and frame_count increments (wrapping).
- With en=0 (and resync=0), all counters hold and hsync/vsync/active hold. line_start and frame_start clear.
- hsync is at HSYNC_POL when H_ACTIVE+H_FP ≤ x ≤ H_ACTIVE+H_FP+H_SYNC-1, otherwise at ~HSYNC_POL.
- vsync is at VSYNC_POL when V_ACTIVE+V_FP ≤ y ≤ V_ACTIVE+V_FP+V_SYNC-1, otherwise at ~VSYNC_POL.
  - vsync changes only together with y, i.e. at the x wrap.
- line_start is 1 for exactly the vgaclk cycle following an edge that moved x to 0.
- frame_start is 1 for exactly the vgaclk cycle following an edge that moved (x,y) to (0,0).
- Both strobes clear on the next edge regardless of en.
- resync=1 at an edge, regardless of en:
  - x and y go to 0.
  - line_start and frame_start are asserted.
  - frame_count is unchanged.
  - resync overrides a simultaneous natural frame wrap, so frame_count does not increment on that edge.
- Reset (reset=0), immediate and asynchronous, can occur mid-frame:
  - x=0, y=0, frame_count=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - active=1
  - line_start=0, frame_start=0
- On release of reset, counting resumes from (0,0) on the first edge with en=1. No strobe is issued for the reset origin.

## Timing
- All outputs are registers on vgaclk.
- hsync, vsync, active, line_start and frame_start are computed from the next counter values. They are therefore cycle-aligned with x/y (zero relative latency). Downstream pixel logic sampling x/y sees matching syncs in the same cycle.
- Frame period with en tied high is H_TOTAL*V_TOTAL vgaclk cycles. Line period is H_TOTAL cycles.
- Strobes are vgaclk-cycle wide, not en-period wide.
- Counters never exceed H_TOTAL-1 or V_TOTAL-1. No out-of-range state is reachable.

## Test plan
- Default parameters, en=1, reset released at cycle 2:
  - hsync low for x=656..751 (96 cycles) in every line.
  - Line period is 800 cycles.
  - vsync low while y=490..491.
  - frame_start pulses every 420000 cycles, and frame_count reads 1 after the first wrap.
  - active=0 at x=640 and at y=480.
- en toggling every other cycle: the frame period is 840000 cycles. x/y/hsync hold during en=0 cycles, and strobes stay one cycle wide.
- Small parameters:
  - Setup: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HSYNC_POL=1, VSYNC_POL=1, FCW=2.
  - hsync is high at x=5..6.
  - vsync is high at y=4.
  - Frame is 48 cycles.
  - frame_count wraps 3→0 after the 4th frame.
- Resync at (x=100,y=200) with frame_count=5: the next cycle shows x=0, y=0, line_start=1, frame_start=1 and frame_count=5.
- Resync on the exact edge of the natural frame wrap: frame_start=1 and frame_count is not incremented.
- Reset asserted mid-line (x=300) and asynchronously between edges: outputs go to the reset values immediately. After release, x=1 follows on the first en edge, with no strobe.
